// File: rtl/sync_pkg.sv
// Shared types and helpers for the synchronizer / debounce blocks.
package sync_pkg;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } db_state_e;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // A qualification length must be at least one sample and must fit in the counter.
  function automatic bit stable_cyc_ok(input int stable_cyc, input int cnt_w);
    return (stable_cyc >= 1) && (stable_cyc <= (1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer with a synchronous reset value; reusable for any 1-bit crossing.
module sync_chain
  import sync_pkg::*;
#(
  parameter int   N       = DEFAULT_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  if (N < 2) begin : g_bad_n
    $error("sync_chain: N must be at least 2");
  end

  logic [N-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {N{RST_VAL}};
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
    end
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronizes a raw asynchronous level and filters it with a tick-throttled
// stability counter; dout only moves after STABLE_CYC consecutive mismatching samples.
module sync_debounce
  import sync_pkg::*;
#(
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int   CNT_W       = 4,
  parameter int   STABLE_CYC  = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic sample_en,
  output logic dout,
  output logic busy
);

  if (!stable_cyc_ok(STABLE_CYC, CNT_W)) begin : g_bad_stable_cyc
    $error("sync_debounce: STABLE_CYC must be in 1..2^CNT_W-1");
  end

  // Count value on which the next mismatching sample completes qualification.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYC - 1);

  logic             w_sync_q;
  logic             w_mismatch;
  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_busy;

  sync_chain #(
    .N       (SYNC_STAGES),
    .RST_VAL (RST_VAL)
  ) u_sync_chain (
    .clk (clk),
    .rst (rst),
    .i_d (din),
    .o_q (w_sync_q)
  );

  assign w_mismatch = w_sync_q ^ r_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DB_STABLE;
      r_cnt   <= '0;
      r_dout  <= RST_VAL;
      r_busy  <= 1'b0;
    end else if (sample_en) begin
      unique case (r_state)
        DB_STABLE: begin
          if (!w_mismatch) begin
            r_cnt <= '0;
          end else if (STABLE_CYC == 1) begin
            r_dout <= w_sync_q;
          end else begin
            r_state <= DB_CHECK;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
          end
        end
        DB_CHECK: begin
          if (!w_mismatch) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LAST_CNT) begin
            r_dout  <= w_sync_q;
            r_state <= DB_STABLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;

  a_cnt_bounded: assert property (@(posedge clk) disable iff (rst) r_cnt <= LAST_CNT);
  a_busy_state:  assert property (@(posedge clk) disable iff (rst) r_busy == (r_state == DB_CHECK));

endmodule

// File: tb/tb_sync_debounce.sv
// Randomized and directed checks of sync_debounce against a history-based reference model.
module tb_sync_debounce;

  localparam int NI = 4;

  // Per-instance parameters, mirrored in the instantiations below.
  function automatic int p_sync(input int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int p_cyc(input int i);
    case (i)
      2:       return 1;
      3:       return 15;
      default: return 4;
    endcase
  endfunction
  function automatic logic p_rst(input int i);
    return (i == 1) ? 1'b1 : 1'b0;
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          sample_en = 1'b1;
  logic [NI-1:0] dout_v;
  logic [NI-1:0] busy_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_debounce u_dut0 (
    .clk(clk), .rst(rst), .din(din), .sample_en(sample_en), .dout(dout_v[0]), .busy(busy_v[0])
  );
  sync_debounce #(.SYNC_STAGES(2), .CNT_W(4), .STABLE_CYC(4), .RST_VAL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .sample_en(sample_en), .dout(dout_v[1]), .busy(busy_v[1])
  );
  sync_debounce #(.SYNC_STAGES(3), .CNT_W(4), .STABLE_CYC(1), .RST_VAL(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .sample_en(sample_en), .dout(dout_v[2]), .busy(busy_v[2])
  );
  sync_debounce #(.SYNC_STAGES(2), .CNT_W(4), .STABLE_CYC(15), .RST_VAL(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .din(din), .sample_en(sample_en), .dout(dout_v[3]), .busy(busy_v[3])
  );

  // Reference model: din history seen at each edge, edges since last reset,
  // and per instance the debounced level plus the current run of mismatching samples.
  logic hist[$];
  int   fresh = 0;
  logic m_dout[NI];
  int   m_run[NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Synchronized value visible to the filter before the current edge.
  function automatic logic model_sync_q(input int i);
    if (fresh >= p_sync(i)) return hist[hist.size() - p_sync(i)];
    return p_rst(i);
  endfunction

  task automatic model_edge(input logic d, input logic en, input logic r);
    for (int i = 0; i < NI; i++) begin
      logic sq;
      sq = model_sync_q(i);
      if (r) begin
        m_dout[i] = p_rst(i);
        m_run[i]  = 0;
      end else if (en) begin
        if (sq != m_dout[i]) begin
          m_run[i]++;
          if (m_run[i] == p_cyc(i)) begin
            m_dout[i] = sq;
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    if (r) begin
      hist.delete();
      fresh = 0;
    end else begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
      if (fresh < 8) fresh++;
    end
  endtask

  task automatic step(input logic d, input logic en, input logic r);
    din       = d;
    sample_en = en;
    rst       = r;
    @(posedge clk);
    model_edge(d, en, r);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("dout%0d", i), 32'(dout_v[i]), 32'(m_dout[i]));
      check($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(m_run[i] > 0));
    end
  endtask

  // Hold din with sample_en=1 and count edges until instance `which` reaches tgt.
  task automatic measure(input logic d, input int which, input logic tgt, output int edges);
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      step(d, 1'b1, 1'b0);
      if (dout_v[which] === tgt) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    int  seen;
    bit  reached;

    for (int i = 0; i < NI; i++) begin
      m_dout[i] = p_rst(i);
      m_run[i]  = 0;
    end

    // Reset with din high, then full latency after release.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1);
    check("reset_dout0", 32'(dout_v[0]), 32'd0);
    check("reset_busy0", 32'(busy_v[0]), 32'd0);
    measure(1'b1, 0, 1'b1, lat);
    check("lat_after_reset", 32'(lat), 32'd6);

    // Clean steps in both directions.
    measure(1'b0, 0, 1'b0, lat);
    check("lat_fall", 32'(lat), 32'd6);
    measure(1'b1, 0, 1'b1, lat);
    check("lat_rise", 32'(lat), 32'd6);
    measure(1'b0, 0, 1'b0, lat);
    check("lat_fall2", 32'(lat), 32'd6);

    // Glitch of three cycles is rejected.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
    check("glitch_busy", 32'(busy_v[0]), 32'd1);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0);
    check("glitch_dout", 32'(dout_v[0]), 32'd0);
    check("glitch_idle", 32'(busy_v[0]), 32'd0);

    // Throttled sampling on every second cycle.
    for (int k = 0; k < 14; k++) step(1'b1, (k % 2) == 0, 1'b0);
    check("throttled_dout", 32'(dout_v[0]), 32'd1);
    measure(1'b0, 0, 1'b0, lat);

    // Reset in the middle of qualification.
    reached = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (m_run[0] == 2) begin
        reached = 1;
        break;
      end
    end
    check("mid_check_reached", 32'(reached), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_mid_dout", 32'(dout_v[0]), 32'd0);
    check("rst_mid_busy", 32'(busy_v[0]), 32'd0);
    measure(1'b1, 0, 1'b1, lat);
    check("lat_requal", 32'(lat), 32'd6);

    // Bounce then settle high (RST_VAL=0 instance).
    measure(1'b0, 0, 1'b0, lat);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step((k % 2) == 0, 1'b1, 1'b0);
      if (dout_v[0] !== 1'b0) seen++;
    end
    check("bounce_hold0", 32'(seen), 32'd0);
    measure(1'b1, 0, 1'b1, lat);
    check("lat_bounce_rise", 32'(lat), 32'd6);

    // Bounce then settle low (RST_VAL=1 instance).
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1);
    check("reset_dout1", 32'(dout_v[1]), 32'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step((k % 2) == 1, 1'b1, 1'b0);
      if (dout_v[1] !== 1'b1) seen++;
    end
    check("bounce_hold1", 32'(seen), 32'd0);
    measure(1'b0, 1, 1'b0, lat);
    check("lat_bounce_fall", 32'(lat), 32'd6);

    // Randomized bursts of held din levels with random ticks and rare resets.
    for (int b = 0; b < 150; b++) begin
      logic d;
      int   len;
      bit   full_rate;
      d         = 1'($urandom_range(0, 1));
      len       = $urandom_range(1, 24);
      full_rate = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < len; k++)
        step(d, full_rate || ($urandom_range(0, 3) != 0), $urandom_range(0, 149) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
